mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
Initiator-side controller for the cache/memory-system request interface. It accepts single-word load/store requests from the pipeline over a valid/ready handshake and drives the memory side (Addr/DataIn/Rd/Wr in, DataOut/Done/Stall/CacheHit back). It holds each request stable until Done and returns read data plus hit/error status over a valid/ready response channel. It also keeps saturating hit/miss counters for performance checks against the cache.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, data word width (byte-lane count = DATA_W/8; word alignment = low 2 bits zero)
TIMEOUT, 64, maximum cycles in WAIT without mem_done before abort (must be >= 1)
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  upstream request present
req_ready  out  1  initiator can accept a request
req_wr  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response available
rsp_ready  in  1  upstream consumes response
rsp_rdata  out  DATA_W  load data (0 for stores/errors)
rsp_hit  out  1  CacheHit sampled with Done
rsp_err  out  1  misaligned address or timeout
mem_addr  out  ADDR_W  address to memory system
mem_data_in  out  DATA_W  write data to memory system
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_data_out  in  DATA_W  read data from memory system
mem_done  in  1  access complete (may be combinational from mem_rd/mem_wr)
mem_stall  in  1  memory system busy, no new access may start
mem_cache_hit  in  1  hit indication, valid only with mem_done
hit_cnt  out  CNT_W  completed accesses with hit
miss_cnt  out  CNT_W  completed accesses without hit

Behaviour:
- All outputs registered except req_ready (= state==IDLE).
- Reset (rst_n=0 at edge): state IDLE; mem_rd=mem_wr=0; mem_addr=mem_data_in=0; rsp_valid=0, rsp_rdata=0, rsp_hit=0, rsp_err=0; hit_cnt=miss_cnt=0; timeout counter 0. Reset mid-access abandons the access; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch addr, wdata, wr.
  - If req_addr[1:0]!=0: go to RESP with rsp_err=1, rsp_rdata=0, rsp_hit=0. No memory access, counters unchanged.
  - Otherwise go to ISSUE.
- ISSUE: mem_rd/mem_wr stay 0 while mem_stall=1 (wait indefinitely; no timeout in ISSUE).
  - When mem_stall=0: register mem_addr (word-aligned), mem_data_in, and mem_rd=~wr / mem_wr=wr; go to WAIT. Exactly one of mem_rd/mem_wr is high in WAIT.
- WAIT: strobes and address/data held stable.
  - On mem_done=1 (first cycle seen, including the first WAIT cycle):
    - capture rsp_rdata = wr ? 0 : mem_data_out; rsp_hit = mem_cache_hit; rsp_err=0.
    - increment hit_cnt if mem_cache_hit, else miss_cnt; both saturate at all-ones.
    - deassert strobes at the same edge; go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with no done: deassert strobes, set rsp_err=1, rsp_rdata=0, rsp_hit=0, counters unchanged; go to RESP.
  - Counter clears on entry to WAIT.
- RESP: rsp_valid=1, payload stable until rsp_ready=1. On that edge: rsp_valid=0, go to IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Zero-wait memory (Done=Rd|Wr, Stall=0) latency: request accepted at edge 0; ISSUE in cycle 1; strobe high in cycle 2 with done; rsp_valid high in cycle 3. Throughput is one request per 4 cycles with rsp_ready tied high.
- mem_done or mem_cache_hit arriving outside WAIT is ignored.

Test Plan:
- Zero-wait memory, load 0x0000_0010 holding 0xDEADBEEF, rsp_ready=1 -> mem_rd high exactly 1 cycle; rsp_valid cycle 3 with rdata 0xDEADBEEF, hit=0, err=0; miss_cnt=1.
- Store 0xCAFEF00D to 0x0000_0020, then load same address -> store response rdata=0, err=0; load returns 0xCAFEF00D; mem_wr high only during the store's WAIT.
- mem_stall=1 for 5 cycles after request -> mem_rd/mem_wr stay 0 for all 5 stall cycles; strobe rises the edge after stall drops; no err.
- Misaligned load at 0x0000_0013 -> no mem_rd/mem_wr ever asserted; rsp_err=1, rdata=0; counters unchanged.
- TIMEOUT=8, mem_done held 0 -> mem_rd high exactly 8 cycles then drops; rsp_err=1; next request proceeds normally.
- Responder forcing mem_cache_hit=1 with rsp_ready stalled 3 cycles, 3 loads -> payload stable while rsp_valid and rsp_ready=0; hit_cnt=3; CNT_W=2 run of 5 hits saturates at 3. Reset asserted during WAIT -> strobes 0 next edge, no rsp_valid.

Source files
------------

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: single-outstanding load/store initiator for the cache/memory request port.
// Each access is held stable until mem_done or timeout; status is returned on a valid/ready channel.
module mem_req_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_cache_hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e state_q, state_d;

  // Only the word part of the address is kept; the byte offset is consumed by the alignment check.
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;

  logic misaligned;
  assign misaligned = (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Done has priority over timeout when both land in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? RESP : ISSUE;
      ISSUE:   if (!mem_stall) state_d = WAIT;
      WAIT:    if (mem_done || (tmo_q == TO_LAST)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:2];
          wdata_d = req_wdata;
          wr_d    = req_wr;
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_hit_d   = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (!mem_stall) begin
          mem_addr_d = {addr_q, 2'b00};
          mem_data_d = wdata_q;
          mem_rd_d   = ~wr_q;
          mem_wr_d   = wr_q;
          tmo_d      = '0;
        end
      end
      WAIT: begin
        if (mem_done) begin
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : mem_data_out;
          rsp_hit_d   = mem_cache_hit;
          rsp_err_d   = 1'b0;
          if (mem_cache_hit) begin
            if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TO_LAST) begin
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_err     = rsp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboard bench for mem_req_initiator: a memory responder with programmable latency,
// a request-level reference model feeding an expectation queue, and an independent monitor.
module tb_mem_req_initiator;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 2;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_hit;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_out;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_cache_hit;
  logic [TB_CNT_W-1:0] hit_cnt;
  logic [TB_CNT_W-1:0] miss_cnt;

  mem_req_initiator #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_cache_hit(mem_cache_hit), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          hit;
    bit          err;
    int          rdCyc;
    int          wrCyc;
    int          hitCnt;
    int          missCnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] refMem [64];
  int          modelHit;
  int          modelMiss;
  int          checks;
  int          failures;

  // Responder state: latency/hit chosen per access, noise drives done/hit when no strobe is up.
  int          latency;
  bit          hitSel;
  bit          noiseDone;
  bit          noiseHit;
  bit          stallRandEn;
  bit          rspRandEn;
  int          accCycles;
  logic [31:0] respMem [64];

  function automatic logic [31:0] initVal(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1234_5678 ^ (i * 32'h9E37_79B1);
  endfunction

  assign mem_done      = (mem_rd | mem_wr) ? (accCycles >= latency) : noiseDone;
  assign mem_cache_hit = (mem_rd | mem_wr) ? hitSel : noiseHit;
  assign mem_data_out  = respMem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) respMem[i] <= initVal(i);
      accCycles <= 0;
    end else begin
      if (mem_wr && mem_done) respMem[mem_addr[7:2]] <= mem_data_in;
      accCycles <= (mem_rd | mem_wr) ? accCycles + 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (stallRandEn) mem_stall = ($urandom_range(0, 2) == 0);
    if (rspRandEn) rsp_ready = ($urandom_range(0, 3) != 0);
    noiseDone = 1'($urandom_range(0, 1));
    noiseHit  = 1'($urandom_range(0, 1));
  endtask

  task automatic resetModel();
    for (int i = 0; i < 64; i++) refMem[i] = initVal(i);
    modelHit  = 0;
    modelMiss = 0;
    sb.delete();
  endtask

  // Presents one request, records what the memory protocol says must come back, returns one cycle after acceptance.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, input bit hit);
    exp_t e;
    int   waited;
    waited = 0;
    tick();
    while (!req_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_accept", {63'd0, req_ready}, 64'd1);
      return;
    end
    latency   = lat;
    hitSel    = hit;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wdata = wdata;
    e.rdata = 32'd0;
    e.hit   = 1'b0;
    e.err   = 1'b0;
    e.rdCyc = 0;
    e.wrCyc = 0;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else if (lat >= TB_TIMEOUT) begin
      e.err = 1'b1;
      if (wr) e.wrCyc = TB_TIMEOUT; else e.rdCyc = TB_TIMEOUT;
    end else begin
      e.hit = hit;
      if (wr) begin
        refMem[addr[7:2]] = wdata;
        e.wrCyc = lat + 1;
      end else begin
        e.rdata = refMem[addr[7:2]];
        e.rdCyc = lat + 1;
      end
      if (hit) modelHit = (modelHit < CNT_MAX) ? modelHit + 1 : CNT_MAX;
      else     modelMiss = (modelMiss < CNT_MAX) ? modelMiss + 1 : CNT_MAX;
    end
    e.hitCnt  = modelHit;
    e.missCnt = modelMiss;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every presented response against the queue head and tracks strobe activity.
  int rdSeen;
  int wrSeen;
  bit prevStrobe;
  bit prevStall;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      rdSeen     = 0;
      wrSeen     = 0;
      prevStrobe = 1'b0;
      prevStall  = 1'b0;
    end else begin
      if (mem_rd) rdSeen++;
      if (mem_wr) wrSeen++;
      if (mem_rd | mem_wr) begin
        checkOutput("strobe_exclusive", {63'd0, mem_rd & mem_wr}, 64'd0);
        if (sb.size() == 0) begin
          checkOutput("strobe_without_request", 64'd1, 64'd0);
        end else begin
          checkOutput("mem_addr", {32'd0, mem_addr}, {32'd0, sb[0].addr});
          if (mem_wr) checkOutput("mem_data_in", {32'd0, mem_data_in}, {32'd0, sb[0].wdata});
        end
        if (!prevStrobe) checkOutput("strobe_rise_while_stalled", {63'd0, prevStall}, 64'd0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_without_request", 64'd1, 64'd0);
        end else begin
          checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, sb[0].rdata});
          checkOutput("rsp_hit", {63'd0, rsp_hit}, {63'd0, sb[0].hit});
          checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, sb[0].err});
          if (rsp_ready) begin
            checkOutput("hit_cnt", 64'(hit_cnt), 64'(sb[0].hitCnt));
            checkOutput("miss_cnt", 64'(miss_cnt), 64'(sb[0].missCnt));
            checkOutput("rd_strobe_cycles", 64'(rdSeen), 64'(sb[0].rdCyc));
            checkOutput("wr_strobe_cycles", 64'(wrSeen), 64'(sb[0].wrCyc));
            void'(sb.pop_front());
            rdSeen = 0;
            wrSeen = 0;
          end
        end
      end
      prevStrobe = mem_rd | mem_wr;
      prevStall  = mem_stall;
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r;
    int lat;
    logic [31:0] addr;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    mem_stall = 1'b0;
    latency = 0;
    hitSel = 1'b0;
    noiseDone = 1'b0;
    noiseHit = 1'b0;
    stallRandEn = 1'b0;
    rspRandEn = 1'b0;
    resetModel();
    repeat (3) tick();
    rst_n = 1'b1;
    checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
    checkOutput("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    checkOutput("reset_mem_data_in", {32'd0, mem_data_in}, 64'd0);
    checkOutput("reset_rsp_payload", {30'd0, rsp_rdata, rsp_hit, rsp_err}, 64'd0);
    checkOutput("reset_counters", {60'd0, hit_cnt, miss_cnt}, 64'd0);

    $display("[TB] zero-wait load");
    applyStimulus(1'b0, 32'h10, 32'd0, 0, 1'b0);
    checkOutput("zw_issue_no_strobe", {62'd0, mem_rd, mem_wr}, 64'd0);
    tick();
    checkOutput("zw_rd_cycle2", {62'd0, mem_rd, mem_wr}, 64'd2);
    tick();
    checkOutput("zw_rsp_cycle3", {62'd0, rsp_valid, mem_rd}, 64'd2);
    drain();

    $display("[TB] store then load");
    applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 0, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'd0, 0, 1'b0);
    drain();

    $display("[TB] stall before issue");
    applyStimulus(1'b0, 32'h24, 32'd0, 0, 1'b1);
    mem_stall = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      if (k == 6) mem_stall = 1'b0;
      if (k < 7) checkOutput("stall_no_strobe", {62'd0, mem_rd, mem_wr}, 64'd0);
      else       checkOutput("stall_strobe_rise", {62'd0, mem_rd, mem_wr}, 64'd2);
    end
    drain();

    $display("[TB] misaligned, timeout, recovery");
    applyStimulus(1'b0, 32'h13, 32'd0, 0, 1'b1);
    applyStimulus(1'b0, 32'h30, 32'd0, 1000, 1'b1);
    applyStimulus(1'b0, 32'h30, 32'd0, 1, 1'b0);
    drain();

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h40, 32'h1111_2222, 1000, 1'b0);
    tick();
    tick();
    checkOutput("pre_reset_strobe", {62'd0, mem_rd, mem_wr}, 64'd1);
    rst_n = 1'b0;
    resetModel();
    tick();
    rst_n = 1'b1;
    checkOutput("mid_reset_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
    checkOutput("mid_reset_counters", {60'd0, hit_cnt, miss_cnt}, 64'd0);
    n = 0;
    for (int k = 0; k < TB_TIMEOUT + 4; k++) begin
      if (rsp_valid) n++;
      tick();
    end
    checkOutput("mid_reset_no_rsp", 64'(n), 64'd0);

    $display("[TB] hit run with response backpressure");
    rsp_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 32'(j * 4 + 8'h80), 32'd0, j % 3, 1'b1);
      n = 0;
      while (!rsp_valid && n < 50) begin
        tick();
        n++;
      end
      checkOutput("hit_rsp_seen", {63'd0, rsp_valid}, 64'd1);
      repeat (3) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    checkOutput("hit_cnt_saturated", 64'(hit_cnt), 64'(CNT_MAX));
    rsp_ready = 1'b1;

    $display("[TB] randomized traffic");
    stallRandEn = 1'b1;
    rspRandEn = 1'b1;
    for (int j = 0; j < 150; j++) begin
      addr = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = 1000;
      else if (r == 1) lat = TB_TIMEOUT - 1;
      else if (r == 2) lat = TB_TIMEOUT;
      else             lat = int'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, lat, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
